// File: rtl/clint_axi.sv
// Core-local interruptor for a dual-hart RISC-V system: MSIP0/1 and SSIP0/1 behind an AXI3 slave.
// Latency: interrupt lines are the register bits; a write beat reaches them the next cycle; read data is combinational.
// Backpressure: one transaction per channel in flight; bvalid/rvalid hold until bready/rready, no timeouts.
//
// Ports: clk_i, rst_i (async active-low) | mipi0_o, mipi1_o, sipi0_o, sipi1_o interrupt lines |
//   aw*/w*/b* write channel | ar*/r* read channel | write_complete pulses on the write-response handshake.
// Build option: define CLINT_SLVERR_EN to answer unmapped accesses with SLVERR; without it they get OKAY.
module clint_axi #(
  parameter logic [31:0] MSIP0_ADDR = 32'h0200_0000,
  parameter logic [31:0] MSIP1_ADDR = 32'h0200_0004,
  parameter logic [31:0] SSIP0_ADDR = 32'h0200_C000,
  parameter logic [31:0] SSIP1_ADDR = 32'h0200_C004
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mipi0_o,
  output logic        mipi1_o,
  output logic        sipi0_o,
  output logic        sipi1_o,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wrdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  output logic        write_complete
);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef CLINT_SLVERR_EN
  localparam logic [1:0] UNMAPPED_RESP = 2'b10;  // SLVERR
`else
  localparam logic [1:0] UNMAPPED_RESP = 2'b00;  // OKAY
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Latched write-address context.
  typedef struct packed {
    logic [29:0] word;
    logic [3:0]  id;
  } wctx_t;

  // Latched read-address context plus remaining-beat counter.
  typedef struct packed {
    logic [29:0] word;
    logic [3:0]  id;
    logic [3:0]  left;
  } rctx_t;

  // Word-address decode: result[2] = mapped, result[1:0] = pending-bit index.
  function automatic logic [2:0] decode(input logic [29:0] word);
    logic [2:0] res;
    res = 3'b000;
    if (word == MSIP0_ADDR[31:2])      res = 3'b100;
    else if (word == MSIP1_ADDR[31:2]) res = 3'b101;
    else if (word == SSIP0_ADDR[31:2]) res = 3'b110;
    else if (word == SSIP1_ADDR[31:2]) res = 3'b111;
    return res;
  endfunction

  // Bit order: [0]=MSIP0, [1]=MSIP1, [2]=SSIP0, [3]=SSIP1.
  logic [3:0] pend_q;

  // Low during reset and for the first cycle after it, so the address channels
  // never advertise ready while the block is held in reset.
  logic live_q;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  wctx_t    wctx_q;
  rctx_t    rctx_q;

  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [2:0] w_dec, r_dec;
  logic       w_hit, r_hit;
  logic [1:0] w_sel, r_sel;

  // Address attributes, ID of data beats and the upper data/strobe lanes have no effect here.
  logic unused_inputs;
  assign unused_inputs = ^{awaddr[1:0], awsize, awburst, awlock, awcache, awprot, wid,
                           wrdata[31:1], wstrb[3:1], araddr[1:0], arsize, arlock, arcache, arprot};

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;

  assign w_dec = decode(wctx_q.word);
  assign w_hit = w_dec[2];
  assign w_sel = w_dec[1:0];
  assign r_dec = decode(rctx_q.word);
  assign r_hit = r_dec[2];
  assign r_sel = r_dec[1:0];

  assign mipi0_o = pend_q[0];
  assign mipi1_o = pend_q[1];
  assign sipi0_o = pend_q[2];
  assign sipi1_o = pend_q[3];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // Pending bits: every strobed beat to a mapped address overwrites, so the last beat wins.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_q <= '0;
    end else if (w_hs && wstrb[0] && w_hit) begin
      pend_q[w_sel] <= wrdata[0];
    end
  end

  // ---------------- write channel ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      w_state_q <= W_IDLE;
      wctx_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        wctx_q.word <= awaddr[31:2];
        wctx_q.id   <= awid;
      end
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs)         w_state_d = W_DATA;
      W_DATA:  if (w_hs && wlast) w_state_d = W_RESP;
      W_RESP:  if (b_hs)          w_state_d = W_IDLE;
      default:                    w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    awready        = 1'b0;
    wready         = 1'b0;
    bvalid         = 1'b0;
    bresp          = RESP_OKAY;
    bid            = wctx_q.id;
    write_complete = 1'b0;
    case (w_state_q)
      W_IDLE: awready = live_q;
      W_DATA: wready  = 1'b1;
      W_RESP: begin
        bvalid         = 1'b1;
        bresp          = w_hit ? RESP_OKAY : UNMAPPED_RESP;
        write_complete = bready;
      end
      default: ;
    endcase
  end

  // ---------------- read channel ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state_q <= R_IDLE;
      rctx_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rctx_q.word <= araddr[31:2];
        rctx_q.id   <= arid;
        rctx_q.left <= arlen;
      end else if (r_hs && (rctx_q.left != 4'd0)) begin
        rctx_q.left <= rctx_q.left - 4'd1;
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs)                          r_state_d = R_DATA;
      R_DATA:  if (r_hs && (rctx_q.left == 4'd0))  r_state_d = R_IDLE;
      default:                                     r_state_d = R_IDLE;
    endcase
  end

  // Read data comes straight from pend_q, so a read in the same cycle as a
  // write to that bit returns the value from before the write.
  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    rresp   = RESP_OKAY;
    rdata   = '0;
    rid     = rctx_q.id;
    case (r_state_q)
      R_IDLE: arready = live_q;
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (rctx_q.left == 4'd0);
        rresp  = r_hit ? RESP_OKAY : UNMAPPED_RESP;
        rdata  = r_hit ? {31'b0, pend_q[r_sel]} : 32'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint_axi.sv
// Bench for clint_axi: directed sequences plus randomized AXI traffic against a register-level model.
// Latency: model bits change one edge after the accepted W beat, matching the interrupt outputs.
// Backpressure: bready/rready are withheld for random cycles to exercise valid holding.
module tb_clint_axi;

  logic        clk, rst_i;
  logic        mipi0_o, mipi1_o, sipi0_o, sipi1_o;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wrdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        write_complete;

  int ncmp = 0;
  int nfail = 0;

  // Model: pending bits in the order MSIP0, MSIP1, SSIP0, SSIP1, plus channel phase flags.
  bit [3:0]   pend = '0;
  bit         wr_resp = 1'b0;
  bit         rd_active = 1'b0;
  int         rd_idx = -1;
  logic [3:0] rd_id = '0;
  int         rd_left = 0;

`ifdef CLINT_SLVERR_EN
  localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

  clint_axi dut (
    .clk_i(clk), .rst_i(rst_i),
    .mipi0_o(mipi0_o), .mipi1_o(mipi1_o), .sipi0_o(sipi0_o), .sipi1_o(sipi1_o),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .write_complete(write_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Index of the pending bit an address maps to, -1 when unmapped; low two address bits ignored.
  function automatic int idx_of(input logic [31:0] a);
    case ({a[31:2], 2'b00})
      32'h0200_0000: return 0;
      32'h0200_0004: return 1;
      32'h0200_C000: return 2;
      32'h0200_C004: return 3;
      default:       return -1;
    endcase
  endfunction

  function automatic logic [1:0] resp_for(input int k);
    return (k >= 0) ? 2'b00 : UNMAP_RESP;
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0:       a = 32'h0200_0000;
      1:       a = 32'h0200_0004;
      2:       a = 32'h0200_C000;
      3:       a = 32'h0200_C004;
      4:       a = 32'h0200_0008;
      default: a = $urandom;
    endcase
    a[1:0] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  // Continuous checker: interrupt lines against the model every cycle, channel valids
  // against the model phase, read beat contents while a read burst is open.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst_i) begin
        chk("rst_irq", 32'({sipi1_o, sipi0_o, mipi1_o, mipi0_o}), 32'h0);
        chk("rst_ready", 32'({awready, wready, arready}), 32'h0);
        chk("rst_valid", 32'({bvalid, rvalid, write_complete}), 32'h0);
        chk("rst_ids", 32'({bid, bresp, rid, rresp, rlast}), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
      end else begin
        chk("irq", 32'({sipi1_o, sipi0_o, mipi1_o, mipi0_o}), 32'(pend));
        chk("bvalid", 32'(bvalid), 32'(wr_resp));
        chk("rvalid", 32'(rvalid), 32'(rd_active));
        if (rd_active) begin
          chk("rdata", rdata, (rd_idx >= 0) ? 32'(pend[rd_idx]) : 32'h0);
          chk("rid", 32'(rid), 32'(rd_id));
          chk("rresp", 32'(rresp), 32'(resp_for(rd_idx)));
          chk("rlast", 32'(rlast), 32'(rd_left == 0));
        end
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input logic [31:0] data, input bit rnd, input int bdly,
                           output logic [1:0] got_resp);
    int k;
    logic [31:0] d;
    logic [3:0] s;
    k = idx_of(addr);
    got_resp = 2'bxx;
    @(negedge clk);
    awaddr = addr; awid = id; awlen = 4'(len);
    awsize = 3'($urandom); awburst = 2'($urandom); awlock = 2'($urandom);
    awcache = 4'($urandom); awprot = 3'($urandom);
    awvalid = 1'b1;
    for (int t = 0; t < 20 && !awready; t++) @(negedge clk);
    chk("awready_wait", 32'(awready), 32'h1);
    if (!awready) begin awvalid = 1'b0; return; end
    @(posedge clk);
    #1 awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      @(negedge clk);
      repeat ($urandom_range(0, 1)) @(negedge clk);
      d = rnd ? 32'($urandom) : data;
      s = rnd ? 4'($urandom) : 4'hF;
      wrdata = d; wstrb = s; wlast = (b == len); wid = 4'($urandom); wvalid = 1'b1;
      for (int t = 0; t < 20 && !wready; t++) @(negedge clk);
      chk("wready_wait", 32'(wready), 32'h1);
      if (!wready) begin wvalid = 1'b0; return; end
      @(posedge clk);
      #1;
      wvalid = 1'b0; wlast = 1'b0;
      if (k >= 0 && s[0]) pend[k] = d[0];
    end
    wr_resp = 1'b1;
    @(negedge clk);
    #1;
    chk("bid", 32'(bid), 32'(id));
    chk("bresp", 32'(bresp), 32'(resp_for(k)));
    chk("wc_early", 32'(write_complete), 32'h0);
    got_resp = bresp;
    repeat (bdly) @(negedge clk);
    bready = 1'b1;
    #1 chk("wc_pulse", 32'(write_complete), 32'h1);
    @(posedge clk);
    #1;
    bready = 1'b0; wr_resp = 1'b0;
    @(negedge clk);
    #1 chk("wc_single", 32'(write_complete), 32'h0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                          input int rdly, output logic [31:0] first_data, output int nlast);
    first_data = '0;
    nlast = 0;
    @(negedge clk);
    araddr = addr; arid = id; arlen = 4'(len);
    arsize = 3'($urandom); arlock = 2'($urandom); arcache = 4'($urandom); arprot = 3'($urandom);
    arvalid = 1'b1;
    for (int t = 0; t < 20 && !arready; t++) @(negedge clk);
    chk("arready_wait", 32'(arready), 32'h1);
    if (!arready) begin arvalid = 1'b0; return; end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    rd_idx = idx_of(addr); rd_id = id; rd_left = len; rd_active = 1'b1;
    for (int b = 0; b <= len; b++) begin
      @(negedge clk);
      repeat (rdly) @(negedge clk);
      rready = 1'b1;
      #1 chk("rvalid_beat", 32'(rvalid), 32'h1);
      if (!rvalid) begin rready = 1'b0; rd_active = 1'b0; return; end
      if (b == 0) first_data = rdata;
      if (rlast) nlast++;
      @(posedge clk);
      #1 rready = 1'b0;
      if (b == len) rd_active = 1'b0;
      else rd_left--;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", ncmp);
    $fatal(1);
  end

  initial begin
    logic [1:0]  r1, r2;
    logic [31:0] fd;
    int          nl;
    logic [31:0] a1, a2;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0;
    awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wrdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arlock = '0; arcache = '0;
    arprot = '0; arvalid = 1'b0; rready = 1'b0;
    rst_i = 1'b0;
    #21 rst_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_awready", 32'(awready), 32'h1);
    chk("idle_arready", 32'(arready), 32'h1);
    chk("idle_irq", 32'({sipi1_o, sipi0_o, mipi1_o, mipi0_o}), 32'h0);

    // Set MSIP0.
    axi_write(32'h0200_0000, 4'h5, 0, 32'h1, 1'b0, 1, r1);
    chk("msip0_set", 32'(mipi0_o), 32'h1);
    chk("msip0_resp", 32'(r1), 32'h0);

    // Set the other three, clear MSIP0.
    axi_write(32'h0200_0004, 4'h1, 0, 32'h1, 1'b0, 0, r1);
    axi_write(32'h0200_C000, 4'h2, 0, 32'h1, 1'b0, 2, r1);
    axi_write(32'h0200_C004, 4'h3, 0, 32'h1, 1'b0, 0, r1);
    axi_write(32'h0200_0000, 4'h4, 0, 32'h0, 1'b0, 0, r1);
    chk("pattern_1110", 32'({sipi1_o, sipi0_o, mipi1_o, mipi0_o}), 32'he);

    // Three-beat read with rready held off for two cycles per beat.
    axi_read(32'h0200_C004, 4'hA, 2, 2, fd, nl);
    chk("ssip1_rdata", fd, 32'h1);
    chk("ssip1_nlast", 32'(nl), 32'h1);

    // Multi-beat write: last strobed beat wins.
    axi_write(32'h0200_0004, 4'h6, 2, 32'h0, 1'b0, 0, r1);
    chk("msip1_cleared", 32'(mipi1_o), 32'h0);
    axi_write(32'h0200_0004, 4'h6, 0, 32'h1, 1'b0, 0, r1);

    // Unmapped accesses.
    axi_write(32'h0200_0008, 4'h7, 0, 32'h1, 1'b0, 0, r1);
    chk("unmapped_bresp", 32'(r1), 32'(UNMAP_RESP));
    chk("unmapped_irq", 32'({sipi1_o, sipi0_o, mipi1_o, mipi0_o}), 32'he);
    axi_read(32'h0200_0008, 4'h8, 1, 0, fd, nl);
    chk("unmapped_rdata", fd, 32'h0);

    // Reset while the write channel is mid-burst.
    @(negedge clk);
    awaddr = 32'h0200_0000; awid = 4'h3; awlen = 4'd3; awvalid = 1'b1;
    @(posedge clk);
    #1 awvalid = 1'b0;
    @(negedge clk);
    wrdata = 32'h1; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    pend[0] = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_wready", 32'(wready), 32'h1);
    chk("mid_mipi0", 32'(mipi0_o), 32'h1);
    rst_i = 1'b0;
    pend = '0;
    #1;
    chk("abort_irq", 32'({sipi1_o, sipi0_o, mipi1_o, mipi0_o}), 32'h0);
    chk("abort_wready", 32'(wready), 32'h0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    axi_write(32'h0200_0000, 4'h9, 0, 32'h1, 1'b0, 0, r1);
    chk("post_rst_mipi0", 32'(mipi0_o), 32'h1);
    chk("post_rst_resp", 32'(r1), 32'h0);

    // Randomized traffic, including overlapping read and write bursts.
    for (int i = 0; i < 60; i++) begin
      a1 = pick_addr();
      a2 = pick_addr();
      case ($urandom_range(0, 2))
        0: axi_write(a1, 4'($urandom), $urandom_range(0, 3), 32'($urandom), 1'b1,
                     $urandom_range(0, 2), r1);
        1: begin
          axi_read(a1, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), fd, nl);
          chk("rand_nlast", 32'(nl), 32'h1);
        end
        default: begin
          fork
            axi_write(a1, 4'($urandom), $urandom_range(0, 3), 32'($urandom), 1'b1,
                      $urandom_range(0, 2), r2);
            axi_read(a2, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 1), fd, nl);
          join
          chk("conc_nlast", 32'(nl), 32'h1);
        end
      endcase
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/clint_axi.md
Name: clint_axi

Overview:
- Core-local interruptor (CLINT) for a dual-hart RISC-V system.
- Holds four software-interrupt pending bits: machine MSIP0/1 and supervisor SSIP0/1.
- Memory-mapped as an AXI3 slave; each bit drives a per-hart interrupt line to the cores.

Parameters:
- MSIP0_ADDR, 32'h0200_0000, address of hart0 machine software-interrupt register
- MSIP1_ADDR, 32'h0200_0004, address of hart1 machine software-interrupt register
- SSIP0_ADDR, 32'h0200_C000, address of hart0 supervisor software-interrupt register
- SSIP1_ADDR, 32'h0200_C004, address of hart1 supervisor software-interrupt register

Ports:
- clk_i in 1: single clock, all logic on rising edge
- rst_i in 1: reset, asynchronous, active-low
- mipi0_o / mipi1_o / sipi0_o / sipi1_o out 1 each: MSIP0 / MSIP1 / SSIP0 / SSIP1 bit0
- awid in 4, awaddr in 32, awlen in 4, awsize in 3, awburst in 2, awlock in 2, awcache in 4, awprot in 3: write address
- awvalid in 1, awready out 1: write address handshake
- wid in 4, wrdata in 32, wstrb in 4, wlast in 1: write data beat
- wvalid in 1, wready out 1: write data handshake
- bid out 4, bresp out 2: write response
- bvalid out 1, bready in 1: write response handshake
- arid in 4, araddr in 32, arlen in 4, arsize in 3, arlock in 2, arcache in 4, arprot in 3: read address
- arvalid in 1, arready out 1: read address handshake
- rid out 4, rdata out 32, rresp out 2, rlast out 1: read data beat
- rvalid out 1, rready in 1: read data handshake
- write_complete out 1: debug, one-cycle pulse on write-response handshake

Behaviour:
- Reset (rst_i=0):
  - all four pending bits = 0, so all interrupt outputs = 0
  - all ready/valid outputs = 0; bid/rid/bresp/rresp/rdata/rlast = 0; write_complete = 0
  - both FSMs return to IDLE
- Interrupt outputs are direct register bits; no added latency.
- Decode compares addr[31:2] against the parameter addresses; addr[1:0], awsize/arsize, awburst, lock/cache/prot and wid are ignored.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: awready=1. On awvalid&awready, latch awaddr and awid, go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready beat with wstrb[0]=1 and a mapped address loads wrdata[0] into the selected bit; other bits are ignored. All beats target the latched address, so the last beat wins. On the beat with wlast=1, go to W_RESP. The bit updates at the clock edge of the beat, so the output changes the cycle after the handshake.
  - W_RESP: bvalid=1, bid=latched awid, bresp=OKAY (2'b00) for mapped addresses. Hold until bready. On bvalid&bready, pulse write_complete for 1 cycle and go to W_IDLE.
- Read FSM (R_IDLE, R_DATA):
  - R_IDLE: arready=1. On arvalid&arready, latch araddr, arid and beat counter=arlen, go to R_DATA.
  - R_DATA: rvalid=1, rid=latched arid, rresp=OKAY, rdata = {31'b0, selected bit}, combinational from the current register value. rlast=1 when counter==0.
  - On rvalid&rready: if last, go to R_IDLE; otherwise decrement the counter.
- Read and write channels are fully independent and may be active at once.
- A read of a bit in the same cycle that bit is written returns the old value.
- Valid outputs are held until their handshake completes; no timeouts.
- Async reset mid-transaction aborts it immediately; the bus sees valid/ready drop.

Optional Feature:
- Macro CLINT_SLVERR_EN.
- Defined: an unmapped write is ignored and answered with bresp=SLVERR (2'b10); an unmapped read returns rdata=0 with rresp=SLVERR on every beat.
- Undefined: unmapped accesses return OKAY; writes are ignored and reads return 0.

Test Plan:
- Release reset at 21 ns, clock period 10 ns -> all interrupt outputs 0; awready=arready=1; bvalid=rvalid=0.
- Write 32'h1, wstrb=4'hF, awlen=0, to 0x0200_0000 -> mipi0_o=1 the cycle after the W beat; bvalid with bresp=0 and bid=awid; write_complete pulses exactly 1 cycle on bready.
- Write 1 to 0x0200_0004, 0x0200_C000 and 0x0200_C004, then 0 to 0x0200_0000 -> mipi0_o=0; mipi1_o=sipi0_o=sipi1_o=1.
- Read 0x0200_C004 with arlen=2 -> 3 beats of rdata=32'h1; rlast only on the 3rd beat; rid=arid; hold rready low 2 cycles and check rvalid stays high.
- Write 1 to 0x0200_0008 -> no output changes; bresp=2'b10 with CLINT_SLVERR_EN defined, 2'b00 without.
- Assert rst_i low while in W_DATA -> all pending bits 0 and FSMs idle; a following write to 0x0200_0000 completes normally.
